// File: rtl/packet_gate_fifo_if.sv
// AXI-Stream beat channel shared by the ingress and egress sides of the packet gate.
interface packet_gate_fifo_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/packet_gate_fifo.sv
// Store-and-decide packet gate: buffers ingress beats and forwards or discards
// whole packets according to a per-packet decision, with saturating statistics.
module packet_gate_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  parameter  int CNT_W  = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  packet_gate_fifo_if.slave   s_axis,
  packet_gate_fifo_if.master  m_axis,
  input  logic                dec_valid,
  input  logic                dec_drop,
  output logic                dec_ready,
  input  logic                filter_en,
  output logic [CNT_W-1:0]    pass_count,
  output logic [CNT_W-1:0]    drop_count,
  output logic [AW:0]         fifo_level
);

  typedef enum logic [1:0] {WAIT, PASS, DROP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       level;
  logic [DATA_W:0]   head;
  logic              full, empty, wr_en, pop, m_xfer;
  logic              got_last;
  logic              m_vld, m_lst;
  logic [DATA_W-1:0] m_dat;

  assign head  = mem[rd_ptr];
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign wr_en = s_axis.tvalid & ~full & ~rst;
  assign m_xfer = m_vld & m_axis.tready;

  assign s_axis.tready = ~rst & ~full;
  assign m_axis.tvalid = m_vld;
  assign m_axis.tdata  = m_dat;
  assign m_axis.tlast  = m_lst;
  assign fifo_level    = level;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    dec_ready = 1'b0;
    case (state)
      WAIT: begin
        if (filter_en) begin
          dec_ready = ~rst;
          if (dec_valid) state_nxt = dec_drop ? DROP : PASS;
        end else if (!empty) begin
          state_nxt = PASS;
        end
      end
      PASS: begin
        // once the tlast beat sits in the output stage, stop popping so the
        // next packet waits for its own decision
        pop = ~empty & ~got_last & (~m_vld | m_axis.tready);
        if (m_xfer && m_lst) state_nxt = WAIT;
      end
      DROP: begin
        pop = ~empty;
        if (pop && head[DATA_W]) state_nxt = WAIT;
      end
      default: state_nxt = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {s_axis.tlast, s_axis.tdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      got_last   <= 1'b0;
      m_vld      <= 1'b0;
      m_dat      <= '0;
      m_lst      <= 1'b0;
      pass_count <= '0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};

      if (pop && state == PASS) begin
        m_vld    <= 1'b1;
        m_dat    <= head[DATA_W-1:0];
        m_lst    <= head[DATA_W];
        got_last <= head[DATA_W];
      end else if (m_xfer) begin
        m_vld <= 1'b0;
      end
      if (m_xfer && m_lst) got_last <= 1'b0;

      if (m_xfer && m_lst && pass_count != '1) pass_count <= pass_count + 1'b1;
      if (state == DROP && pop && head[DATA_W] && drop_count != '1)
        drop_count <= drop_count + 1'b1;
    end
  end

endmodule
